if_id_skid_reg: RTL and testbench

IF/ID boundary register with a 2-entry skid buffer, placed directly downstream of the fetch stage and feeding decode. It captures each fetched instruction, its PC and its static branch predictions. It absorbs in-flight fetch responses while decode is stalled, and drives the PC-write enable back to fetch, so the PC advances exactly when a fetched beat is accepted. A flush drops all buffered work and presents a bubble to decode.

---
 rtl/if_id_skid_reg.sv | 170 +++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a 2-entry skid FIFO and PC-write handshake.
// Optional: define IF_ID_BR_PRED_EN to carry static branch predictions.
package pkg;
    typedef struct packed {
        logic staticBT_pred;
        logic staticBTFNT_pred;
    } ctrl_flow_preds;
endpackage

module if_id_skid_reg
    import pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    IF_pc_i,
    input  logic [31:0]    IF_instr_i,
    input  logic           IF_imem_resp_i,
    input  ctrl_flow_preds IF_br_pred_i,
    input  logic           ID_stall_i,
    input  logic           flush_i,
    output logic           IF_PC_write_o,
    output logic [31:0]    ID_pc_o,
    output logic [31:0]    ID_instr_o,
    output logic           ID_valid_o,
    output ctrl_flow_preds ID_br_pred_o,
    output logic [1:0]     skid_count_o
);

    localparam logic [1:0]  FULL = 2'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        advance;
    logic        accept;
    logic        push;

    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

`ifdef IF_ID_BR_PRED_EN
    ctrl_flow_preds pred_q, pred_d;
    ctrl_flow_preds pred_mem_q [DEPTH];
`endif

    assign advance = !ID_stall_i;
    assign accept  = IF_imem_resp_i && !flush_i &&
                     ((count_q < FULL) || advance);

    // Fetch may move its PC only when the beat is taken or redirected.
    assign IF_PC_write_o = flush_i || accept;

    // Next-state for FIFO bookkeeping and the decode-facing register.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
`ifdef IF_ID_BR_PRED_EN
        pred_d   = pred_q;
`endif
        push     = 1'b0;

        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            valid_d  = 1'b0;
            pc_d     = '0;
            instr_d  = NOP;
`ifdef IF_ID_BR_PRED_EN
            pred_d   = '0;
`endif
        end else if (advance) begin
            if (count_q != 2'd0) begin
                valid_d  = 1'b1;
                pc_d     = pc_mem_q[rd_ptr_q];
                instr_d  = instr_mem_q[rd_ptr_q];
`ifdef IF_ID_BR_PRED_EN
                pred_d   = pred_mem_q[rd_ptr_q];
`endif
                rd_ptr_d = rd_ptr_q + 1'b1;
                push     = accept;
                if (!accept) begin
                    count_d = count_q - 2'd1;
                end
            end else if (accept) begin
                valid_d = 1'b1;
                pc_d    = IF_pc_i;
                instr_d = IF_instr_i;
`ifdef IF_ID_BR_PRED_EN
                pred_d  = IF_br_pred_i;
`endif
            end else begin
                valid_d = 1'b0;
                pc_d    = '0;
                instr_d = NOP;
`ifdef IF_ID_BR_PRED_EN
                pred_d  = '0;
`endif
            end
        end else if (accept) begin
            push    = 1'b1;
            count_d = count_q + 2'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // State register; reset forces the bubble and an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= NOP;
`ifdef IF_ID_BR_PRED_EN
            pred_q   <= '0;
`endif
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
`ifdef IF_ID_BR_PRED_EN
            pred_q   <= pred_d;
`endif
        end
    end

    // Skid storage; entries are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem_q[wr_ptr_q]    <= IF_pc_i;
            instr_mem_q[wr_ptr_q] <= IF_instr_i;
`ifdef IF_ID_BR_PRED_EN
            pred_mem_q[wr_ptr_q]  <= IF_br_pred_i;
`endif
        end
    end

    assign ID_valid_o   = valid_q;
    assign ID_pc_o      = pc_q;
    assign ID_instr_o   = instr_q;
    assign skid_count_o = count_q;

`ifdef IF_ID_BR_PRED_EN
    assign ID_br_pred_o = pred_q;
`else
    logic unused_pred;
    assign unused_pred  = ^IF_br_pred_i;
    assign ID_br_pred_o = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_if_id_skid_reg;
    import pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    IF_pc_i;
    logic [31:0]    IF_instr_i;
    logic           IF_imem_resp_i;
    ctrl_flow_preds IF_br_pred_i;
    logic           ID_stall_i;
    logic           flush_i;
    logic           IF_PC_write_o;
    logic [31:0]    ID_pc_o;
    logic [31:0]    ID_instr_o;
    logic           ID_valid_o;
    ctrl_flow_preds ID_br_pred_o;
    logic [1:0]     skid_count_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]    pc;
        logic [31:0]    instr;
        ctrl_flow_preds pred;
    } beat_t;

    if_id_skid_reg dut (
        .clk           (clk),
        .rst           (rst),
        .IF_pc_i       (IF_pc_i),
        .IF_instr_i    (IF_instr_i),
        .IF_imem_resp_i(IF_imem_resp_i),
        .IF_br_pred_i  (IF_br_pred_i),
        .ID_stall_i    (ID_stall_i),
        .flush_i       (flush_i),
        .IF_PC_write_o (IF_PC_write_o),
        .ID_pc_o       (ID_pc_o),
        .ID_instr_o    (ID_instr_o),
        .ID_valid_o    (ID_valid_o),
        .ID_br_pred_o  (ID_br_pred_o),
        .skid_count_o  (skid_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'h1234_5000;
    endfunction

    function automatic ctrl_flow_preds exp_pred(input ctrl_flow_preds p);
`ifdef IF_ID_BR_PRED_EN
        return p;
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic resp, input logic [31:0] pc,
                         input logic [31:0] instr, input logic stall,
                         input logic flush, input ctrl_flow_preds pred);
        IF_imem_resp_i = resp;
        IF_pc_i        = pc;
        IF_instr_i     = instr;
        ID_stall_i     = stall;
        flush_i        = flush;
        IF_br_pred_i   = pred;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        tick();
        tests++;
        if (ID_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", ID_valid_o);
        end
        tests++;
        if (ID_instr_o !== 32'h0000_0013) begin
            fails++;
            $display("FAIL reset_instr: got %h want 00000013", ID_instr_o);
        end
        tests++;
        if (ID_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc: got %h want 0", ID_pc_o);
        end
        tests++;
        if (skid_count_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d want 0", skid_count_o);
        end
        tests++;
        if (IF_PC_write_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_pcw: got %b want 0", IF_PC_write_o);
        end
        tests++;
        if (ID_br_pred_o !== ctrl_flow_preds'(2'b00)) begin
            fails++;
            $display("FAIL reset_pred: got %b want 00", ID_br_pred_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            pc = 32'h60 + 32'(4 * i);
            drive(1'b1, pc, mk_instr(pc), 1'b0, 1'b0, '0);
            #1;
            tests++;
            if (IF_PC_write_o !== 1'b1) begin
                fails++;
                $display("FAIL stream_pcw%0d: got %b want 1", i, IF_PC_write_o);
            end
            tick();
            tests++;
            if (ID_pc_o !== pc || ID_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL stream_pc%0d: got %h/%b want %h/1",
                         i, ID_pc_o, ID_valid_o, pc);
            end
            tests++;
            if (ID_instr_o !== mk_instr(pc)) begin
                fails++;
                $display("FAIL stream_instr%0d: got %h want %h",
                         i, ID_instr_o, mk_instr(pc));
            end
            tests++;
            if (skid_count_o !== 2'd0) begin
                fails++;
                $display("FAIL stream_count%0d: got %0d want 0", i, skid_count_o);
            end
        end
    endtask

    task automatic test_stall_fill();
        logic [31:0] exp_pc [3];
        logic [1:0]  exp_cnt [3];
        logic [31:0] pc;
        exp_pc  = '{32'h64, 32'h68, 32'h6C};
        exp_cnt = '{2'd2, 2'd1, 2'd0};
        reset_dut();
        drive(1'b1, 32'h60, mk_instr(32'h60), 1'b0, 1'b0, '0);
        tick();
        for (int i = 1; i < 3; i++) begin
            pc = 32'h60 + 32'(4 * i);
            drive(1'b1, pc, mk_instr(pc), 1'b1, 1'b0, '0);
            tick();
            tests++;
            if (skid_count_o !== 2'(i) || ID_pc_o !== 32'h60) begin
                fails++;
                $display("FAIL fill_hold%0d: got cnt %0d pc %h want %0d/60",
                         i, skid_count_o, ID_pc_o, i);
            end
        end
        drive(1'b1, 32'h6C, mk_instr(32'h6C), 1'b1, 1'b0, '0);
        #1;
        tests++;
        if (IF_PC_write_o !== 1'b0) begin
            fails++;
            $display("FAIL fill_full_pcw: got %b want 0", IF_PC_write_o);
        end
        tick();
        tests++;
        if (skid_count_o !== 2'd2) begin
            fails++;
            $display("FAIL fill_full_count: got %0d want 2", skid_count_o);
        end
        drive(1'b1, 32'h6C, mk_instr(32'h6C), 1'b0, 1'b0, '0);
        #1;
        tests++;
        if (IF_PC_write_o !== 1'b1) begin
            fails++;
            $display("FAIL fill_release_pcw: got %b want 1", IF_PC_write_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ID_pc_o !== exp_pc[i] || ID_valid_o !== 1'b1 ||
                skid_count_o !== exp_cnt[i]) begin
                fails++;
                $display("FAIL drain%0d: got %h/%b/%0d want %h/1/%0d", i,
                         ID_pc_o, ID_valid_o, skid_count_o,
                         exp_pc[i], exp_cnt[i]);
            end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        end
        tick();
        tests++;
        if (ID_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL drain_bubble: got %b want 0", ID_valid_o);
        end
    endtask

    task automatic test_flush_full();
        reset_dut();
        drive(1'b1, 32'h80, mk_instr(32'h80), 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 32'h84, mk_instr(32'h84), 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 32'h100, mk_instr(32'h100), 1'b1, 1'b1, '0);
        #1;
        tests++;
        if (IF_PC_write_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_pcw: got %b want 1", IF_PC_write_o);
        end
        tick();
        tests++;
        if (skid_count_o !== 2'd0 || ID_valid_o !== 1'b0 ||
            ID_instr_o !== 32'h13 || ID_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL flush_state: got %0d/%b/%h/%h want 0/0/13/0",
                     skid_count_o, ID_valid_o, ID_instr_o, ID_pc_o);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        tests++;
        if (ID_valid_o !== 1'b0 || skid_count_o !== 2'd0) begin
            fails++;
            $display("FAIL flush_dropped: got %b/%0d want 0/0",
                     ID_valid_o, skid_count_o);
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] exp_pc [3];
        logic [1:0]  exp_cnt [3];
        exp_pc  = '{32'h40, 32'h44, 32'h70};
        exp_cnt = '{2'd2, 2'd1, 2'd0};
        reset_dut();
        drive(1'b1, 32'h40, mk_instr(32'h40), 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 32'h44, mk_instr(32'h44), 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 32'h70, mk_instr(32'h70), 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ID_pc_o !== exp_pc[i] || skid_count_o !== exp_cnt[i] ||
                ID_instr_o !== mk_instr(exp_pc[i])) begin
                fails++;
                $display("FAIL poppush%0d: got %h/%0d want %h/%0d", i,
                         ID_pc_o, skid_count_o, exp_pc[i], exp_cnt[i]);
            end
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_pred_carry();
        ctrl_flow_preds p1;
        ctrl_flow_preds p0;
        p1 = '0;
        p1.staticBTFNT_pred = 1'b1;
        p0 = '0;
        reset_dut();
        drive(1'b1, 32'h200, mk_instr(32'h200), 1'b1, 1'b0, p1);
        tick();
        drive(1'b1, 32'h204, mk_instr(32'h204), 1'b1, 1'b0, p0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        tests++;
        if (ID_pc_o !== 32'h200 || ID_br_pred_o !== exp_pred(p1)) begin
            fails++;
            $display("FAIL pred_first: got %h/%b want 200/%b",
                     ID_pc_o, ID_br_pred_o, exp_pred(p1));
        end
        tick();
        tests++;
        if (ID_pc_o !== 32'h204 || ID_br_pred_o !== exp_pred(p0)) begin
            fails++;
            $display("FAIL pred_second: got %h/%b want 204/%b",
                     ID_pc_o, ID_br_pred_o, exp_pred(p0));
        end
    endtask

    task automatic test_random();
        beat_t       q [$];
        beat_t       b;
        beat_t       out;
        logic        out_v;
        logic        r_rst, r_resp, r_stall, r_flush, acc;
        logic [1:0]  pr;
        logic [31:0] pc;
        reset_dut();
        out.pc    = 32'h0;
        out.instr = 32'h13;
        out.pred  = '0;
        out_v     = 1'b0;
        pc        = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            r_rst   = ($urandom_range(99) < 2);
            r_flush = ($urandom_range(99) < 5);
            r_stall = ($urandom_range(99) < 40);
            r_resp  = ($urandom_range(99) < 75);
            pr      = 2'($urandom_range(3));
            b.pc    = pc;
            b.instr = $urandom;
            b.pred  = pr;
            rst     = r_rst;
            drive(r_resp, b.pc, b.instr, r_stall, r_flush, b.pred);
            acc = r_resp && !r_flush && (q.size() < 2 || !r_stall);
            #1;
            tests++;
            if (IF_PC_write_o !== (r_flush || acc)) begin
                fails++;
                $display("FAIL rnd_pcw c%0d: got %b want %b",
                         c, IF_PC_write_o, r_flush || acc);
            end
            if (r_flush) pc = {$urandom_range(16'hffff), 2'b00};
            else if (acc) pc = pc + 32'd4;
            tick();
            if (r_rst || r_flush) begin
                q.delete();
                out.pc = 32'h0; out.instr = 32'h13; out.pred = '0;
                out_v  = 1'b0;
            end else begin
                if (acc) q.push_back(b);
                if (!r_stall) begin
                    if (q.size() > 0) begin
                        out   = q.pop_front();
                        out_v = 1'b1;
                    end else begin
                        out.pc = 32'h0; out.instr = 32'h13; out.pred = '0;
                        out_v  = 1'b0;
                    end
                end
            end
            tests++;
            if (ID_valid_o !== out_v || ID_pc_o !== out.pc ||
                ID_instr_o !== out.instr) begin
                fails++;
                $display("FAIL rnd_out c%0d: got %b/%h/%h want %b/%h/%h", c,
                         ID_valid_o, ID_pc_o, ID_instr_o,
                         out_v, out.pc, out.instr);
            end
            tests++;
            if (skid_count_o !== 2'(q.size())) begin
                fails++;
                $display("FAIL rnd_count c%0d: got %0d want %0d",
                         c, skid_count_o, q.size());
            end
            tests++;
            if (ID_br_pred_o !== exp_pred(out.pred)) begin
                fails++;
                $display("FAIL rnd_pred c%0d: got %b want %b",
                         c, ID_br_pred_o, exp_pred(out.pred));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush_full();
        test_full_pop_push();
        test_pred_carry();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
